// File: rtl/dbg_jtag_host.sv
// JTAG host engine: expands RESET / IR scan / DR scan / IDLE commands into TCK/TMS/TDI
// sequences and returns captured TDO. Optional trst_n output via `DBG_JTAG_HOST_TRST_EN.
module dbg_jtag_host #(
    parameter int CLK_DIV    = 2,
    parameter int DATA_WIDTH = 64,
    parameter int LEN_W      = $clog2(DATA_WIDTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_vld,
    output logic                  cmd_rdy,
    input  logic [1:0]            cmd_type,
    input  logic [LEN_W-1:0]      cmd_len,
    input  logic [DATA_WIDTH-1:0] cmd_data,
    output logic                  rsp_vld,
    input  logic                  rsp_rdy,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  tck,
    output logic                  tms,
    output logic                  tdi,
    input  logic                  tdo
`ifdef DBG_JTAG_HOST_TRST_EN
    ,
    output logic                  trst_n
`endif
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_PRE   = 3'd1;
    localparam logic [2:0] ST_SHIFT = 3'd2;
    localparam logic [2:0] ST_POST  = 3'd3;
    localparam logic [2:0] ST_RSP   = 3'd4;

    localparam logic [1:0] CMD_RESET = 2'd0;
    localparam logic [1:0] CMD_IR    = 2'd1;
    localparam logic [1:0] CMD_DR    = 2'd2;
    localparam logic [1:0] CMD_IDLE  = 2'd3;

    // TMS preambles, LSB is the first bit presented.
    localparam logic [5:0] PAT_RESET = 6'b011111;
    localparam logic [5:0] PAT_IR    = 6'b000011;
    localparam logic [5:0] PAT_DR    = 6'b000001;

    localparam int              DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [2:0]            state;
    logic [1:0]            kind;
    logic [DIV_W-1:0]      div_cnt;
    logic [2:0]            pre_left;
    logic [LEN_W-1:0]      shift_left;
    logic                  post_second;
    logic [5:0]            pre_pat;
    logic [DATA_WIDTH-1:0] data_sr;
    logic [DATA_WIDTH-1:0] cap_mask;

    logic                  accept;
    logic                  running;
    logic                  fall_tick;
    logic [LEN_W-1:0]      scan_len;
    logic                  is_idle;

    assign accept    = (state == ST_IDLE) && cmd_vld && cmd_rdy;
    assign running   = (state == ST_PRE) || (state == ST_SHIFT) || (state == ST_POST);
    assign fall_tick = running && tck && (div_cnt == DIV_LAST);
    assign is_idle   = (kind == CMD_IDLE);

    always_comb begin
        scan_len = cmd_len;
        if (cmd_len == '0)
            scan_len = LEN_W'(1);
        else if (cmd_len > LEN_W'(DATA_WIDTH))
            scan_len = LEN_W'(DATA_WIDTH);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            kind        <= CMD_RESET;
            cmd_rdy     <= 1'b0;
            rsp_vld     <= 1'b0;
            rsp_data    <= '0;
            tck         <= 1'b0;
            tms         <= 1'b1;
            tdi         <= 1'b0;
            div_cnt     <= '0;
            pre_left    <= '0;
            shift_left  <= '0;
            post_second <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    tck     <= 1'b0;
                    tms     <= 1'b0;
                    tdi     <= 1'b0;
                    div_cnt <= '0;
                    if (accept) begin
                        cmd_rdy     <= 1'b0;
                        kind        <= cmd_type;
                        rsp_data    <= '0;
                        post_second <= 1'b0;
                        shift_left  <= (cmd_type == CMD_IDLE) ? cmd_len - LEN_W'(1)
                                                              : scan_len - LEN_W'(1);
                        case (cmd_type)
                            CMD_RESET: begin
                                state    <= ST_PRE;
                                pre_left <= 3'd5;
                                tms      <= 1'b1;
                            end
                            CMD_IR: begin
                                state    <= ST_PRE;
                                pre_left <= 3'd3;
                                tms      <= 1'b1;
                            end
                            CMD_DR: begin
                                state    <= ST_PRE;
                                pre_left <= 3'd2;
                                tms      <= 1'b1;
                            end
                            default: begin
                                if (cmd_len == '0) begin
                                    state   <= ST_RSP;
                                    rsp_vld <= 1'b1;
                                end else begin
                                    state <= ST_SHIFT;
                                end
                            end
                        endcase
                    end else begin
                        cmd_rdy <= 1'b1;
                    end
                end

                ST_PRE, ST_SHIFT, ST_POST: begin
                    if (div_cnt != DIV_LAST) begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end else begin
                        div_cnt <= '0;
                        tck     <= ~tck;
                        if (!tck) begin
                            // Rising TCK: TDO was launched by the TAP on the previous falling edge.
                            if (state == ST_SHIFT && !is_idle)
                                rsp_data <= rsp_data | ({DATA_WIDTH{tdo}} & cap_mask);
                        end else begin
                            case (state)
                                ST_PRE: begin
                                    if (pre_left != '0) begin
                                        pre_left <= pre_left - 3'd1;
                                        tms      <= pre_pat[1];
                                    end else if (kind == CMD_RESET) begin
                                        state   <= ST_RSP;
                                        rsp_vld <= 1'b1;
                                        tms     <= 1'b0;
                                    end else begin
                                        state <= ST_SHIFT;
                                        tms   <= (shift_left == '0);
                                        tdi   <= data_sr[0];
                                    end
                                end
                                ST_SHIFT: begin
                                    if (shift_left != '0) begin
                                        shift_left <= shift_left - LEN_W'(1);
                                        tms        <= !is_idle && (shift_left == LEN_W'(1));
                                        tdi        <= !is_idle && data_sr[1];
                                    end else if (is_idle) begin
                                        state   <= ST_RSP;
                                        rsp_vld <= 1'b1;
                                        tms     <= 1'b0;
                                        tdi     <= 1'b0;
                                    end else begin
                                        state <= ST_POST;
                                        tms   <= 1'b1;
                                        tdi   <= 1'b0;
                                    end
                                end
                                default: begin
                                    if (!post_second) begin
                                        post_second <= 1'b1;
                                        tms         <= 1'b0;
                                    end else begin
                                        state   <= ST_RSP;
                                        rsp_vld <= 1'b1;
                                        tms     <= 1'b0;
                                    end
                                end
                            endcase
                        end
                    end
                end

                ST_RSP: begin
                    tck <= 1'b0;
                    tms <= 1'b0;
                    tdi <= 1'b0;
                    if (rsp_rdy) begin
                        rsp_vld <= 1'b0;
                        cmd_rdy <= 1'b1;
                        state   <= ST_IDLE;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

    // NOTE: shift/pattern registers carry no reset; every command reloads them on acceptance
    // and the control FSM never reads them before that.
    always_ff @(posedge clk) begin
        if (accept) begin
            data_sr  <= cmd_data;
            cap_mask <= DATA_WIDTH'(1);
            case (cmd_type)
                CMD_RESET: pre_pat <= PAT_RESET;
                CMD_IR:    pre_pat <= PAT_IR;
                default:   pre_pat <= PAT_DR;
            endcase
        end else if (fall_tick) begin
            if (state == ST_PRE && pre_left != '0)
                pre_pat <= pre_pat >> 1;
            if (state == ST_SHIFT && shift_left != '0) begin
                data_sr  <= data_sr >> 1;
                cap_mask <= cap_mask << 1;
            end
        end
    end

`ifdef DBG_JTAG_HOST_TRST_EN
    // trst_n is released after the second TCK of a RESET preamble has fallen.
    always_ff @(posedge clk) begin
        if (rst)
            trst_n <= 1'b0;
        else if (accept && cmd_type == CMD_RESET)
            trst_n <= 1'b0;
        else if (fall_tick && state == ST_PRE && kind == CMD_RESET && pre_left == 3'd4)
            trst_n <= 1'b1;
        else if (state == ST_IDLE)
            trst_n <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_dbg_jtag_host.sv
// Directed bench for dbg_jtag_host: drives commands against a behavioural TAP
// (IDCODE and a 64-bit test data register) and checks sequences, data and latency.
module tb_dbg_jtag_host;

    localparam int DW = 64;
    localparam int LW = $clog2(DW + 1);
    localparam int CLK_DIV = 2;

    localparam logic [3:0] TLR = 4'd0, RTI = 4'd1, SEL_DR = 4'd2, CAP_DR = 4'd3,
                           SH_DR = 4'd4, EX1_DR = 4'd5, PA_DR = 4'd6, EX2_DR = 4'd7,
                           UPD_DR = 4'd8, SEL_IR = 4'd9, CAP_IR = 4'd10, SH_IR = 4'd11,
                           EX1_IR = 4'd12, PA_IR = 4'd13, EX2_IR = 4'd14, UPD_IR = 4'd15;

    localparam logic [4:0]  IR_IDCODE  = 5'h01;
    localparam logic [4:0]  IR_TDR     = 5'h11;
    localparam logic [31:0] IDCODE_VAL = 32'hDEAD_BEEF;
    localparam logic [63:0] TDR_INIT   = 64'h0123_4567_89AB_CDEF;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_vld;
    logic          cmd_rdy;
    logic [1:0]    cmd_type;
    logic [LW-1:0] cmd_len;
    logic [DW-1:0] cmd_data;
    logic          rsp_vld;
    logic          rsp_rdy;
    logic [DW-1:0] rsp_data;
    logic          tck;
    logic          tms;
    logic          tdi;
    logic          tdo = 1'b0;
`ifdef DBG_JTAG_HOST_TRST_EN
    logic          trst_n;
`endif

    int checks;
    int errors;

    dbg_jtag_host #(.CLK_DIV(CLK_DIV), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy), .cmd_type(cmd_type), .cmd_len(cmd_len),
        .cmd_data(cmd_data),
        .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_data(rsp_data),
        .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo)
`ifdef DBG_JTAG_HOST_TRST_EN
        , .trst_n(trst_n)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- TAP model ----------------
    logic [3:0]  tap_state = PA_DR;
    logic [4:0]  ir = 5'h00;
    logic [4:0]  ir_sr = 5'h00;
    logic [63:0] dr_sr = 64'h0;
    logic [63:0] tdr = 64'h0;
    int          dr_len = 1;

    function automatic logic [3:0] tap_next(input logic [3:0] s, input logic m);
        case (s)
            TLR:    return m ? TLR    : RTI;
            RTI:    return m ? SEL_DR : RTI;
            SEL_DR: return m ? SEL_IR : CAP_DR;
            CAP_DR: return m ? EX1_DR : SH_DR;
            SH_DR:  return m ? EX1_DR : SH_DR;
            EX1_DR: return m ? UPD_DR : PA_DR;
            PA_DR:  return m ? EX2_DR : PA_DR;
            EX2_DR: return m ? UPD_DR : SH_DR;
            UPD_DR: return m ? SEL_DR : RTI;
            SEL_IR: return m ? TLR    : CAP_IR;
            CAP_IR: return m ? EX1_IR : SH_IR;
            SH_IR:  return m ? EX1_IR : SH_IR;
            EX1_IR: return m ? UPD_IR : PA_IR;
            PA_IR:  return m ? EX2_IR : PA_IR;
            EX2_IR: return m ? UPD_IR : SH_IR;
            default: return m ? SEL_DR : RTI;
        endcase
    endfunction

    always @(posedge tck) begin
        case (tap_state)
            TLR: begin ir <= IR_IDCODE; tdr <= TDR_INIT; end
            CAP_IR: ir_sr <= 5'b00001;
            SH_IR:  ir_sr <= {tdi, ir_sr[4:1]};
            UPD_IR: ir <= ir_sr;
            CAP_DR: begin
                if (ir == IR_IDCODE) begin dr_sr <= {32'h0, IDCODE_VAL}; dr_len <= 32; end
                else if (ir == IR_TDR) begin dr_sr <= tdr; dr_len <= 64; end
                else begin dr_sr <= 64'h0; dr_len <= 1; end
            end
            SH_DR: begin
                if (dr_len == 64) dr_sr <= {tdi, dr_sr[63:1]};
                else if (dr_len == 32) dr_sr[31:0] <= {tdi, dr_sr[31:1]};
                else dr_sr[0] <= tdi;
            end
            UPD_DR: if (ir == IR_TDR) tdr <= dr_sr;
            default: ;
        endcase
        tap_state <= tap_next(tap_state, tms);
    end

    always @(negedge tck)
        tdo <= (tap_state == SH_DR) ? dr_sr[0] : (tap_state == SH_IR) ? ir_sr[0] : 1'b0;

    // ---------------- TCK edge monitor ----------------
    int   edge_total = 0;
    int   edge_base = 0;
    logic tms_hist [0:4095];
    logic tdi_hist [0:4095];

    always @(posedge tck) begin
        if (edge_total < 4096) begin
            tms_hist[edge_total] = tms;
            tdi_hist[edge_total] = tdi;
        end
        edge_total++;
    end

    function automatic logic [127:0] tms_bits(input int base, input int n);
        logic [127:0] v;
        v = '0;
        for (int i = 0; i < n && i < 128; i++) v[i] = tms_hist[base + i];
        return v;
    endfunction

    function automatic logic [127:0] tdi_bits(input int base, input int n);
        logic [127:0] v;
        v = '0;
        for (int i = 0; i < n && i < 128; i++) v[i] = tdi_hist[base + i];
        return v;
    endfunction

    // ---------------- command helpers ----------------
    logic first_tck, first_tms;

    // Returns at the falling clk edge of cycle A+1 (A = acceptance edge).
    task automatic send_cmd(input logic [1:0] t, input logic [LW-1:0] l, input logic [DW-1:0] d);
        int budget;
        @(negedge clk);
        cmd_type = t;
        cmd_len  = l;
        cmd_data = d;
        cmd_vld  = 1'b1;
        budget   = 0;
        while (cmd_rdy !== 1'b1 && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        if (cmd_rdy !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL cmd_accept: cmd_rdy=%b required 1", cmd_rdy);
        end
        edge_base = edge_total;
        @(posedge clk);
        @(negedge clk);
        cmd_vld   = 1'b0;
        first_tck = tck;
        first_tms = tms;
    endtask

    task automatic wait_rsp(output int lat);
        int k;
        k = 1;
        while (rsp_vld !== 1'b1 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        lat = (rsp_vld === 1'b1) ? k : -1;
    endtask

    task automatic take_rsp(output logic [DW-1:0] data, output logic rdy_after);
        data    = rsp_data;
        rsp_rdy = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_rdy   = 1'b0;
        rdy_after = cmd_rdy;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (cmd_rdy !== 1'b0) begin errors++; $display("FAIL rst_cmd_rdy: got %b want 0", cmd_rdy); end
        checks++; if (rsp_vld !== 1'b0) begin errors++; $display("FAIL rst_rsp_vld: got %b want 0", rsp_vld); end
        checks++; if (rsp_data !== '0) begin errors++; $display("FAIL rst_rsp_data: got %h want 0", rsp_data); end
        checks++; if (tck !== 1'b0) begin errors++; $display("FAIL rst_tck: got %b want 0", tck); end
        checks++; if (tms !== 1'b1) begin errors++; $display("FAIL rst_tms: got %b want 1", tms); end
        checks++; if (tdi !== 1'b0) begin errors++; $display("FAIL rst_tdi: got %b want 0", tdi); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (cmd_rdy !== 1'b1) begin errors++; $display("FAIL post_rst_cmd_rdy: got %b want 1", cmd_rdy); end
    endtask

    task automatic test_tap_reset();
        int lat; logic [DW-1:0] d; logic r; logic [127:0] v;
        send_cmd(2'd0, '0, '0);
        checks++; if ({first_tck, first_tms} !== 2'b01) begin errors++; $display("FAIL reset_first_bit: tck,tms=%b want 01", {first_tck, first_tms}); end
        wait_rsp(lat);
        checks++; if (lat != 25) begin errors++; $display("FAIL reset_latency: got %0d want 25", lat); end
        take_rsp(d, r);
        checks++; if (d !== '0) begin errors++; $display("FAIL reset_rsp_data: got %h want 0", d); end
        checks++; if (edge_total - edge_base != 6) begin errors++; $display("FAIL reset_tck_count: got %0d want 6", edge_total - edge_base); end
        v = tms_bits(edge_base, 6);
        checks++; if (v !== 128'h1F) begin errors++; $display("FAIL reset_tms_seq: got %h want 1f", v); end
        checks++; if (tap_state !== RTI) begin errors++; $display("FAIL reset_tap_state: got %0d want %0d", tap_state, RTI); end
        checks++; if (ir !== IR_IDCODE) begin errors++; $display("FAIL reset_ir: got %h want 01", ir); end
    endtask

    task automatic test_idcode();
        int lat; logic [DW-1:0] d; logic r;
        send_cmd(2'd2, LW'(32), '0);
        wait_rsp(lat);
        take_rsp(d, r);
        checks++; if (lat != 1 + 4 * 37) begin errors++; $display("FAIL idcode_latency: got %0d want %0d", lat, 1 + 4 * 37); end
        checks++; if (d !== {32'h0, IDCODE_VAL}) begin errors++; $display("FAIL idcode_data: got %h want deadbeef", d); end
        checks++; if (edge_total - edge_base != 37) begin errors++; $display("FAIL idcode_tck_count: got %0d want 37", edge_total - edge_base); end
    endtask

    task automatic test_ir_scan();
        int lat; logic [DW-1:0] d; logic r; logic [127:0] v;
        send_cmd(2'd1, LW'(5), 64'h11);
        wait_rsp(lat);
        take_rsp(d, r);
        checks++; if (lat != 45) begin errors++; $display("FAIL ir_latency: got %0d want 45", lat); end
        checks++; if (edge_total - edge_base != 11) begin errors++; $display("FAIL ir_tck_count: got %0d want 11", edge_total - edge_base); end
        v = tms_bits(edge_base, 11);
        checks++; if (v !== 128'h303) begin errors++; $display("FAIL ir_tms_seq: got %h want 303", v); end
        v = tdi_bits(edge_base, 11);
        checks++; if (v !== 128'h110) begin errors++; $display("FAIL ir_tdi_seq: got %h want 110", v); end
        checks++; if (d !== 64'h1) begin errors++; $display("FAIL ir_rsp_data: got %h want 1", d); end
        checks++; if (ir !== IR_TDR) begin errors++; $display("FAIL ir_value: got %h want 11", ir); end
    endtask

    task automatic test_len_clamp();
        int lat; logic [DW-1:0] d; logic r;
        send_cmd(2'd2, LW'(100), 64'hCAFE_F00D_1234_5678);
        wait_rsp(lat);
        take_rsp(d, r);
        checks++; if (lat != 1 + 4 * 69) begin errors++; $display("FAIL clamp_latency: got %0d want %0d", lat, 1 + 4 * 69); end
        checks++; if (edge_total - edge_base != 69) begin errors++; $display("FAIL clamp_tck_count: got %0d want 69", edge_total - edge_base); end
        checks++; if (d !== TDR_INIT) begin errors++; $display("FAIL clamp_rsp_data: got %h want %h", d, TDR_INIT); end
        send_cmd(2'd2, LW'(64), 64'h3);
        wait_rsp(lat);
        take_rsp(d, r);
        checks++; if (d !== 64'hCAFE_F00D_1234_5678) begin errors++; $display("FAIL full64_rsp_data: got %h want cafef00d12345678", d); end
    endtask

    task automatic test_len_zero();
        int lat; logic [DW-1:0] d; logic r; logic [127:0] v;
        send_cmd(2'd2, '0, '0);
        wait_rsp(lat);
        take_rsp(d, r);
        checks++; if (lat != 25) begin errors++; $display("FAIL len0_latency: got %0d want 25", lat); end
        checks++; if (edge_total - edge_base != 6) begin errors++; $display("FAIL len0_tck_count: got %0d want 6", edge_total - edge_base); end
        v = tms_bits(edge_base, 6);
        checks++; if (v !== 128'h19) begin errors++; $display("FAIL len0_tms_seq: got %h want 19", v); end
        checks++; if (d !== 64'h1) begin errors++; $display("FAIL len0_rsp_data: got %h want 1", d); end
    endtask

    task automatic test_idle();
        int lat; logic [DW-1:0] d; logic r; logic [127:0] v;
        send_cmd(2'd3, '0, '1);
        wait_rsp(lat);
        take_rsp(d, r);
        checks++; if (lat != 1) begin errors++; $display("FAIL idle0_latency: got %0d want 1", lat); end
        checks++; if (edge_total - edge_base != 0) begin errors++; $display("FAIL idle0_tck_count: got %0d want 0", edge_total - edge_base); end
        send_cmd(2'd3, LW'(3), '1);
        wait_rsp(lat);
        take_rsp(d, r);
        checks++; if (lat != 13) begin errors++; $display("FAIL idle3_latency: got %0d want 13", lat); end
        checks++; if (edge_total - edge_base != 3) begin errors++; $display("FAIL idle3_tck_count: got %0d want 3", edge_total - edge_base); end
        v = tms_bits(edge_base, 3) | tdi_bits(edge_base, 3);
        checks++; if (v !== 128'h0) begin errors++; $display("FAIL idle3_tms_tdi: got %h want 0", v); end
        checks++; if (d !== '0) begin errors++; $display("FAIL idle3_rsp_data: got %h want 0", d); end
        checks++; if (tap_state !== RTI) begin errors++; $display("FAIL idle3_tap_state: got %0d want %0d", tap_state, RTI); end
    endtask

    task automatic test_backpressure();
        int lat; logic [DW-1:0] d; logic r;
        send_cmd(2'd2, LW'(8), 64'hA5);
        wait_rsp(lat);
        checks++; if (lat != 1 + 4 * 13) begin errors++; $display("FAIL bp_latency: got %0d want %0d", lat, 1 + 4 * 13); end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if ({rsp_vld, tck, tms, cmd_rdy} !== 4'b1000 || rsp_data !== 64'h1) begin
                errors++;
                $display("FAIL bp_hold cycle %0d: vld,tck,tms,rdy=%b data=%h want 1000 data=1",
                         i, {rsp_vld, tck, tms, cmd_rdy}, rsp_data);
            end
        end
        take_rsp(d, r);
        checks++; if (r !== 1'b1) begin errors++; $display("FAIL bp_cmd_rdy_after: got %b want 1", r); end
        checks++; if (rsp_vld !== 1'b0) begin errors++; $display("FAIL bp_rsp_vld_after: got %b want 0", rsp_vld); end
    endtask

    task automatic test_rst_mid();
        int lat; int budget; int spurious; logic [DW-1:0] d; logic r;
        send_cmd(2'd2, LW'(32), 64'hFFFF_FFFF);
        budget = 0;
        while (edge_total - edge_base < 10 && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        checks++; if (edge_total - edge_base != 10) begin errors++; $display("FAIL mid_tck_reach: got %0d want 10", edge_total - edge_base); end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({tck, tms, tdi, rsp_vld, cmd_rdy} !== 5'b01000) begin
            errors++;
            $display("FAIL mid_rst_outputs: tck,tms,tdi,vld,rdy=%b want 01000", {tck, tms, tdi, rsp_vld, cmd_rdy});
        end
        rst = 1'b0;
        spurious = 0;
        repeat (30) begin
            @(negedge clk);
            if (rsp_vld === 1'b1) spurious++;
        end
        checks++; if (spurious != 0) begin errors++; $display("FAIL mid_no_response: got %0d cycles with rsp_vld, want 0", spurious); end
        send_cmd(2'd0, '0, '0);
        wait_rsp(lat);
        take_rsp(d, r);
        checks++; if (lat != 25) begin errors++; $display("FAIL mid_reset_latency: got %0d want 25", lat); end
        send_cmd(2'd2, LW'(32), '0);
        wait_rsp(lat);
        take_rsp(d, r);
        checks++; if (d !== {32'h0, IDCODE_VAL}) begin errors++; $display("FAIL mid_idcode: got %h want deadbeef", d); end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rst      = 1'b1;
        cmd_vld  = 1'b0;
        cmd_type = 2'd0;
        cmd_len  = '0;
        cmd_data = '0;
        rsp_rdy  = 1'b0;

        test_reset();
        test_tap_reset();
        test_idcode();
        test_ir_scan();
        test_len_clamp();
        test_len_zero();
        test_idle();
        test_backpressure();
        test_rst_mid();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
